// File: rtl/if_fetch_stage_if.sv
// Instruction SRAM-like request/response bus between the fetch stage and the
// instruction memory.
//   inst_sram_req      fetch request valid (fetch side -> memory)
//   inst_sram_addr     fetch address       (fetch side -> memory)
//   inst_sram_addr_ok  request accepted this cycle, qualified by req
//   inst_sram_data_ok  one in-order response returns this cycle
//   inst_sram_rdata    response instruction word
interface if_fetch_stage_if;
    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    modport master (
        output inst_sram_req,
        output inst_sram_addr,
        input  inst_sram_addr_ok,
        input  inst_sram_data_ok,
        input  inst_sram_rdata
    );

    modport slave (
        input  inst_sram_req,
        input  inst_sram_addr,
        output inst_sram_addr_ok,
        output inst_sram_data_ok,
        output inst_sram_rdata
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage. Owns the fetch PC, issues requests on the inst SRAM
// bus, tracks in-flight PCs, buffers returned words in order and presents the
// head entry {pc, inst, adef} to the decoder. A redirect flushes the buffer,
// restarts fetch and drops responses still in flight.
// Ports:
//   clk, resetn                     clock, async active-low reset
//   inst_sram (master)              req/addr out, addr_ok/data_ok/rdata in
//   redirect, redirect_pc           flush and restart at redirect_pc
//   id_allowin                      decoder consumes the head entry
//   if_valid/if_pc/if_inst/if_adef  head entry (all zero when empty)
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h1C00_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic             clk,
    input  logic             resetn,
    if_fetch_stage_if.master inst_sram,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    input  logic             id_allowin,
    output logic             if_valid,
    output logic [31:0]      if_pc,
    output logic [31:0]      if_inst,
    output logic             if_adef
);
    localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OCC_W = CNT_W + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adef;
    } fetch_entry_t;

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        halted_q, halted_d;
    logic [CNT_W-1:0] outst_q, outst_d;
    logic [CNT_W-1:0] discard_q, discard_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [PTR_W-1:0] pcq_head_q, pcq_head_d, pcq_tail_q, pcq_tail_d;

    fetch_entry_t ent_q [BUF_DEPTH];
    logic [31:0]  pcq_q [BUF_DEPTH];

    logic         req_c, acc_c, dok_c, drop_c, ret_c, adef_c, pop_c;
    logic         ent_we_c, pcq_we_c;
    fetch_entry_t ent_wdata_c;
    logic [OCC_W-1:0] occ_c;
    fetch_entry_t head_c;

    // Request/response qualification; a data_ok with nothing in flight is stale.
    always_comb begin
        occ_c  = OCC_W'(outst_q) + OCC_W'(cnt_q);
        req_c  = resetn && !redirect && !halted_q && (fetch_pc_q[1:0] == 2'b00)
                 && (occ_c < OCC_W'(BUF_DEPTH));
        acc_c  = req_c && inst_sram.inst_sram_addr_ok;
        dok_c  = inst_sram.inst_sram_data_ok && ((outst_q != '0) || (discard_q != '0));
        drop_c = dok_c && (discard_q != '0);
        ret_c  = dok_c && (discard_q == '0);
        adef_c = (fetch_pc_q[1:0] != 2'b00) && !halted_q && (outst_q == '0)
                 && (cnt_q < CNT_W'(BUF_DEPTH));
        pop_c  = (cnt_q != '0) && id_allowin;
    end

    // Next-state: redirect overrides everything else in the cycle.
    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        halted_d    = halted_q;
        outst_d     = outst_q;
        discard_d   = discard_q;
        cnt_d       = cnt_q;
        head_d      = head_q;
        tail_d      = tail_q;
        pcq_head_d  = pcq_head_q;
        pcq_tail_d  = pcq_tail_q;
        ent_we_c    = 1'b0;
        ent_wdata_c = '0;
        pcq_we_c    = 1'b0;

        if (redirect) begin
            fetch_pc_d = redirect_pc;
            halted_d   = 1'b0;
            discard_d  = outst_q + discard_q - CNT_W'(dok_c);
            outst_d    = '0;
            cnt_d      = '0;
            head_d     = '0;
            tail_d     = '0;
            pcq_head_d = '0;
            pcq_tail_d = '0;
        end else begin
            if (pop_c) begin
                head_d = head_q + PTR_W'(1);
            end
            if (drop_c) begin
                discard_d = discard_q - CNT_W'(1);
            end
            if (ret_c) begin
                ent_we_c    = 1'b1;
                ent_wdata_c = '{pc: pcq_q[pcq_head_q], inst: inst_sram.inst_sram_rdata, adef: 1'b0};
                pcq_head_d  = pcq_head_q + PTR_W'(1);
            end else if (adef_c) begin
                ent_we_c    = 1'b1;
                ent_wdata_c = '{pc: fetch_pc_q, inst: 32'h0, adef: 1'b1};
                halted_d    = 1'b1;
            end
            if (ent_we_c) begin
                tail_d = tail_q + PTR_W'(1);
            end
            cnt_d = cnt_q + CNT_W'(ent_we_c) - CNT_W'(pop_c);
            if (acc_c) begin
                pcq_we_c   = 1'b1;
                pcq_tail_d = pcq_tail_q + PTR_W'(1);
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            outst_d = outst_q + CNT_W'(acc_c) - CNT_W'(ret_c);
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fetch_pc_q <= RESET_PC;
            halted_q   <= 1'b0;
            outst_q    <= '0;
            discard_q  <= '0;
            cnt_q      <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            pcq_head_q <= '0;
            pcq_tail_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            halted_q   <= halted_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            cnt_q      <= cnt_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            pcq_head_q <= pcq_head_d;
            pcq_tail_q <= pcq_tail_d;
        end
    end

    // Storage arrays; contents are only observed through valid counters.
    always_ff @(posedge clk) begin
        if (ent_we_c) begin
            ent_q[tail_q] <= ent_wdata_c;
        end
        if (pcq_we_c) begin
            pcq_q[pcq_tail_q] <= fetch_pc_q;
        end
    end

    assign inst_sram.inst_sram_req  = req_c;
    assign inst_sram.inst_sram_addr = fetch_pc_q;

    assign head_c   = ent_q[head_q];
    assign if_valid = (cnt_q != '0);
    assign if_pc    = if_valid ? head_c.pc   : 32'h0;
    assign if_inst  = if_valid ? head_c.inst : 32'h0;
    assign if_adef  = if_valid ? head_c.adef : 1'b0;
endmodule
